// File: rtl/pc_seq.sv
// ---------------------------------------------------------------------------
// pc_seq -- program-counter sequencer for a small instruction-driven datapath.
//
// Fetches 32-bit instructions from a combinational instruction memory, resolves
// control flow (JMP / JNZ / ZNJ) internally, and hands every other instruction
// to the datapath through a valid/ready handshake.  A CHECK instruction's
// datapath result (chk_nz) is captured into an internal flag that steers the
// conditional jumps.  Execution stops in HALT on a detected end loop (done)
// or when the retired-instruction watchdog expires (timeout).
//
// Instruction format: op[31:28] opcode, op[27:20] jump target.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset
//   start      in   1   pulse that (re)starts execution at START_PC
//   op         in  32   instruction word at address pc
//   pc         out  8   instruction address
//   ir         out 32   instruction currently issued
//   exe_valid  out  1   ir holds a datapath instruction awaiting acceptance
//   exe_ready  in   1   datapath accepts ir
//   chk_nz     in   1   CHECK result, sampled on a CHECK handshake
//   busy       out  1   running (not IDLE / HALT)
//   done       out  1   halted on an end loop
//   timeout    out  1   halted on watchdog expiry
//   steps      out 24   retired instructions since start (saturating)
// ---------------------------------------------------------------------------
module pc_seq #(
    parameter logic [7:0]  START_PC  = 8'd0,
    parameter logic [23:0] MAX_STEPS = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op,
    output logic [7:0]  pc,
    output logic [31:0] ir,
    output logic        exe_valid,
    input  logic        exe_ready,
    input  logic        chk_nz,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [23:0] steps
);

    // Opcode encodings (op[31:28]); everything else goes to the datapath.
    localparam logic [3:0] OPC_CHECK = 4'h3;
    localparam logic [3:0] OPC_JMP   = 4'h8;
    localparam logic [3:0] OPC_JNZ   = 4'h9;
    localparam logic [3:0] OPC_ZNJ   = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_HALT
    } state_t;

    state_t      state_reg;
    logic [7:0]  pc_reg;
    logic [31:0] ir_reg;
    logic        exe_valid_reg;
    logic        flag_reg;
    logic [23:0] steps_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        timeout_reg;
    // Address of the most recently retired instruction when that was a JMP;
    // used to spot two JMPs bouncing between each other.
    logic        last_jmp_valid_reg;
    logic [7:0]  last_jmp_addr_reg;

    logic [3:0]  opcode;
    logic [7:0]  target;
    logic [7:0]  pc_plus1;
    logic [23:0] steps_next;
    logic        wd_hit;
    logic        end_loop;

    assign opcode   = ir_reg[31:28];
    assign target   = ir_reg[27:20];
    // 8-bit add wraps FF -> 00 on its own.
    assign pc_plus1 = pc_reg + 8'd1;

    // Saturating increment: the watchdog halts at MAX_STEPS, so steps never wraps.
    assign steps_next = (steps_reg == MAX_STEPS) ? steps_reg : steps_reg + 24'd1;
    assign wd_hit     = (steps_next == MAX_STEPS);

    // pc still holds the JMP's own address while it sits in ISSUE.
    assign end_loop = (target == pc_reg) ||
                      (last_jmp_valid_reg && (target == last_jmp_addr_reg));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg          <= ST_IDLE;
            pc_reg             <= START_PC;
            ir_reg             <= 32'd0;
            exe_valid_reg      <= 1'b0;
            flag_reg           <= 1'b0;
            steps_reg          <= 24'd0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            timeout_reg        <= 1'b0;
            last_jmp_valid_reg <= 1'b0;
            last_jmp_addr_reg  <= 8'd0;
        end else begin
            case (state_reg)
                // HALT holds everything until a new start; restart clears status.
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_reg          <= ST_FETCH;
                        pc_reg             <= START_PC;
                        steps_reg          <= 24'd0;
                        flag_reg           <= 1'b0;
                        done_reg           <= 1'b0;
                        timeout_reg        <= 1'b0;
                        busy_reg           <= 1'b1;
                        last_jmp_valid_reg <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    ir_reg    <= op;
                    state_reg <= ST_ISSUE;
                end

                ST_ISSUE: begin
                    case (opcode)
                        OPC_JMP: begin
                            steps_reg <= steps_next;
                            if (end_loop) begin
                                // End loop wins over the watchdog; pc stays on the JMP.
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= ST_HALT;
                            end else begin
                                pc_reg             <= target;
                                last_jmp_valid_reg <= 1'b1;
                                last_jmp_addr_reg  <= pc_reg;
                                if (wd_hit) begin
                                    timeout_reg <= 1'b1;
                                    busy_reg    <= 1'b0;
                                    state_reg   <= ST_HALT;
                                end else begin
                                    state_reg <= ST_FETCH;
                                end
                            end
                        end

                        OPC_JNZ, OPC_ZNJ: begin
                            // JNZ branches on flag=1, ZNJ on flag=0.
                            if (flag_reg == (opcode == OPC_JNZ)) begin
                                pc_reg <= target;
                            end else begin
                                pc_reg <= pc_plus1;
                            end
                            steps_reg          <= steps_next;
                            last_jmp_valid_reg <= 1'b0;
                            if (wd_hit) begin
                                timeout_reg <= 1'b1;
                                busy_reg    <= 1'b0;
                                state_reg   <= ST_HALT;
                            end else begin
                                state_reg <= ST_FETCH;
                            end
                        end

                        default: begin
                            exe_valid_reg <= 1'b1;
                            state_reg     <= ST_WAIT;
                        end
                    endcase
                end

                ST_WAIT: begin
                    if (exe_ready) begin
                        exe_valid_reg      <= 1'b0;
                        pc_reg             <= pc_plus1;
                        steps_reg          <= steps_next;
                        last_jmp_valid_reg <= 1'b0;
                        if (opcode == OPC_CHECK) begin
                            flag_reg <= chk_nz;
                        end
                        if (wd_hit) begin
                            timeout_reg <= 1'b1;
                            busy_reg    <= 1'b0;
                            state_reg   <= ST_HALT;
                        end else begin
                            state_reg <= ST_FETCH;
                        end
                    end
                end

                default: begin
                    state_reg     <= ST_IDLE;
                    busy_reg      <= 1'b0;
                    exe_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = pc_reg;
    assign ir        = ir_reg;
    assign exe_valid = exe_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign timeout   = timeout_reg;
    assign steps     = steps_reg;

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 The block SHALL have parameter START_PC, default 8'd0, giving the pc loaded on start.
REQ-002 The block SHALL have parameter MAX_STEPS, default 24'hFFFFFF, giving the watchdog limit on retired instructions.
REQ-003 Opcode encodings (JMP, JNZ, ZNJ, CHECK, all others) SHALL come from def.h; JMP/JNZ/ZNJ target is op[27:20].
REQ-004 Port clk  input  1  rising-edge clock; the block has one clock.
REQ-005 Port rst_n  input  1  reset, synchronous and active-low.
REQ-006 Port start  input  1  single-cycle pulse that begins program execution.
REQ-007 Port op  input  32  instruction word from the combinational instruction memory, addressed by pc.
REQ-008 Port pc  output  8  instruction address to the instruction memory.
REQ-009 Port ir  output  32  registered instruction currently issued to the datapath.
REQ-010 Port exe_valid  output  1  ir holds a datapath instruction awaiting acceptance.
REQ-011 Port exe_ready  input  1  datapath accepts ir; may stay low for multi-cycle rotations.
REQ-012 Port chk_nz  input  1  CHECK result (1 = nonzero); sampled only on a CHECK handshake.
REQ-013 Port busy  output  1  high in every state except IDLE and HALT.
REQ-014 Port done  output  1  high in HALT after a detected end loop.
REQ-015 Port timeout  output  1  high in HALT after the watchdog expires.
REQ-016 Port steps  output  24  count of retired instructions since start.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, ISSUE, WAIT and HALT.
REQ-018 IDLE: on start=1, pc<=START_PC, steps<=0, flag<=0, and the FSM SHALL go to FETCH next cycle; otherwise it stays in IDLE.
REQ-019 FETCH: ir<=op, and the FSM SHALL go to ISSUE; the fetch latency is one cycle per instruction.
REQ-020 ISSUE with JMP: pc<=target, steps+1, and the FSM SHALL go to FETCH.
REQ-021 ISSUE with JNZ: pc<=target if flag=1, else pc+1; steps+1; the FSM SHALL go to FETCH.
REQ-022 ISSUE with ZNJ: pc<=target if flag=0, else pc+1; steps+1; the FSM SHALL go to FETCH.
REQ-023 ISSUE with any other opcode: exe_valid<=1, and the FSM SHALL go to WAIT.
REQ-024 WAIT: exe_valid SHALL stay high and ir stable until a cycle with exe_ready=1.
REQ-025 On that handshake cycle: exe_valid<=0, pc<=pc+1, steps+1, flag<=chk_nz if ir is CHECK, and the FSM SHALL go to FETCH.
REQ-026 The flag SHALL change only on a CHECK handshake; control-flow instructions never touch it.
REQ-027 pc+1 SHALL wrap modulo 256 (8'hFF -> 8'h00).
REQ-028 End-loop detection: a JMP whose target equals its own address, or a JMP directly following a retired JMP whose target equals that earlier JMP's address, SHALL set done=1 and the FSM SHALL go to HALT instead of FETCH.
REQ-029 Watchdog: when an instruction retires with steps reaching MAX_STEPS, the FSM SHALL set timeout=1 and go to HALT; steps SHALL saturate and never wrap.
REQ-030 If the end loop and watchdog fire in the same cycle, done SHALL take priority and timeout SHALL stay 0.
REQ-031 HALT: pc, ir, steps, done and timeout SHALL hold; start=1 SHALL clear done and timeout and re-enter as in IDLE.
REQ-032 start SHALL be ignored in FETCH, ISSUE and WAIT.
REQ-033 exe_valid SHALL never be high for a JMP, JNZ or ZNJ.

Reset
REQ-034 On a clock edge with rst_n=0, outputs SHALL become: state IDLE, pc=START_PC, ir=0, exe_valid=0, flag=0, steps=0, busy=0, done=0, timeout=0.
REQ-035 Reset SHALL take effect even mid-WAIT; an outstanding exe_valid SHALL drop the next cycle and the instruction is not retired.

Verification
REQ-036 start; program 0:CHECK, 1:JNZ 5; chk_nz=1 -> pc sequence 0,1,5; flag=1; steps=2.
REQ-037 The same program with chk_nz=0 -> pc goes 0,1,2; ZNJ at 2 with target 9 -> pc=9.
REQ-038 exe_ready held low 4 cycles on an RTX90 -> exe_valid high 4 cycles, ir stable, pc unchanged; pc+1 after the handshake.
REQ-039 71:JMP 72, 72:JMP 71 -> HALT after the JMP at 72; done=1, busy=0, pc holds.
REQ-040 MAX_STEPS=3 with an ADD loop -> timeout=1 after the 3rd retirement; done=0; steps=3.
REQ-041 rst_n=0 during WAIT -> next cycle exe_valid=0, pc=0, state IDLE; pc=8'hFF non-control instruction -> pc wraps to 0.
